// File: rtl/tx_beam_pkg.sv
// Shared types and default widths for the transmit beam pulser.
package tx_beam_pkg;

  localparam int unsigned DELAY_W = 8;
  localparam int unsigned HALF_W  = 4;
  localparam int unsigned CYC_W   = 4;

  typedef enum logic [2:0] {
    CH_IDLE  = 3'd0,
    CH_WAIT  = 3'd1,
    CH_POS   = 3'd2,
    CH_DEAD1 = 3'd3,
    CH_NEG   = 3'd4,
    CH_DEAD2 = 3'd5
  } ch_state_t;

  typedef enum logic [1:0] {
    T_IDLE = 2'd0,
    T_RUN  = 2'd1,
    T_DONE = 2'd2
  } top_state_t;

endpackage

// File: rtl/tx_pulse_channel.sv
// One element's burst sequencer: start delay, then N bipolar cycles of
// pos / dead / neg / dead, with all phases timed by a shared down-counter.
module tx_pulse_channel
  import tx_beam_pkg::*;
#(
  parameter int unsigned DELAY_W = tx_beam_pkg::DELAY_W,
  parameter int unsigned HALF_W  = tx_beam_pkg::HALF_W,
  parameter int unsigned CYC_W   = tx_beam_pkg::CYC_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               kill,
  input  logic [DELAY_W-1:0] delay,
  input  logic [HALF_W-1:0]  half_period,
  input  logic [HALF_W-1:0]  dead_time,
  input  logic [CYC_W-1:0]   num_cycles,
  output logic               pos,
  output logic               neg,
  output logic               idle_c
);

  localparam int unsigned TMR_W = (DELAY_W > HALF_W) ? DELAY_W : HALF_W;

  ch_state_t          state, state_nxt;
  logic [TMR_W-1:0]   tmr, tmr_nxt;
  logic [TMR_W-1:0]   h_load, d_load;
  logic [CYC_W-1:0]   cyc, cyc_nxt;
  logic               end_cyc;

  // Timer reload values; a zero half-period behaves as one clock.
  assign h_load = (half_period == '0) ? '0 : TMR_W'(half_period - HALF_W'(1));
  assign d_load = (dead_time == '0)   ? '0 : TMR_W'(dead_time - HALF_W'(1));

  always_comb begin
    state_nxt = state;
    tmr_nxt   = (tmr == '0) ? tmr : tmr - TMR_W'(1);
    cyc_nxt   = cyc;
    end_cyc   = 1'b0;
    case (state)
      CH_IDLE: begin
        if (start && (num_cycles != '0)) begin
          cyc_nxt = num_cycles - CYC_W'(1);
          if (delay == '0) begin
            state_nxt = CH_POS;
            tmr_nxt   = h_load;
          end else begin
            state_nxt = CH_WAIT;
            tmr_nxt   = TMR_W'(delay - DELAY_W'(1));
          end
        end
      end
      CH_WAIT: begin
        if (tmr == '0) begin
          state_nxt = CH_POS;
          tmr_nxt   = h_load;
        end
      end
      CH_POS: begin
        if (tmr == '0) begin
          if (dead_time != '0) begin
            state_nxt = CH_DEAD1;
            tmr_nxt   = d_load;
          end else begin
            state_nxt = CH_NEG;
            tmr_nxt   = h_load;
          end
        end
      end
      CH_DEAD1: begin
        if (tmr == '0) begin
          state_nxt = CH_NEG;
          tmr_nxt   = h_load;
        end
      end
      CH_NEG: begin
        if (tmr == '0) begin
          if (dead_time != '0) begin
            state_nxt = CH_DEAD2;
            tmr_nxt   = d_load;
          end else begin
            end_cyc = 1'b1;
          end
        end
      end
      CH_DEAD2: begin
        if (tmr == '0) end_cyc = 1'b1;
      end
      default: state_nxt = CH_IDLE;
    endcase

    // End of one bipolar cycle: either start the next or finish the burst.
    if (end_cyc) begin
      if (cyc == '0) begin
        state_nxt = CH_IDLE;
      end else begin
        cyc_nxt   = cyc - CYC_W'(1);
        state_nxt = CH_POS;
        tmr_nxt   = h_load;
      end
    end

    if (kill) state_nxt = CH_IDLE;
  end

  // Lets the top finish the event in the same cycle the last channel idles.
  assign idle_c = (state_nxt == CH_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= CH_IDLE;
      tmr   <= '0;
      cyc   <= '0;
      pos   <= 1'b0;
      neg   <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
      cyc   <= cyc_nxt;
      pos   <= (state_nxt == CH_POS);
      neg   <= (state_nxt == CH_NEG);
    end
  end

endmodule

// File: rtl/tx_beam_pulser.sv
// Transmit beam pulser: latches per-element delays and burst shape on fire,
// runs one burst channel per element and reports busy/done for the event.
module tx_beam_pulser
  import tx_beam_pkg::*;
#(
  parameter int unsigned NUM_ELEM = 8,
  parameter int unsigned DELAY_W  = tx_beam_pkg::DELAY_W,
  parameter int unsigned HALF_W   = tx_beam_pkg::HALF_W,
  parameter int unsigned CYC_W    = tx_beam_pkg::CYC_W
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        fire,
  input  logic                        abort,
  input  logic [NUM_ELEM*DELAY_W-1:0] delays,
  input  logic [HALF_W-1:0]           half_period,
  input  logic [HALF_W-1:0]           dead_time,
  input  logic [CYC_W-1:0]            num_cycles,
  output logic [NUM_ELEM-1:0]         posOutput,
  output logic [NUM_ELEM-1:0]         negOutput,
  output logic                        busy,
  output logic                        done
);

  top_state_t                  state, state_nxt;
  logic [NUM_ELEM*DELAY_W-1:0] dly_q, dly_eff;
  logic [HALF_W-1:0]           h_q, d_q, h_eff, d_eff;
  logic [CYC_W-1:0]            n_q, n_eff;
  logic                        start_c, kill_c, all_idle_c;
  logic [NUM_ELEM-1:0]         ch_idle_c, ch_pos, ch_neg;

  assign start_c    = (state == T_IDLE) && fire && !abort;
  assign kill_c     = (state == T_RUN) && abort;
  assign all_idle_c = &ch_idle_c;

  // Channels see the live inputs on the accepting edge, the latched copy after.
  assign dly_eff = start_c ? delays      : dly_q;
  assign h_eff   = start_c ? half_period : h_q;
  assign d_eff   = start_c ? dead_time   : d_q;
  assign n_eff   = start_c ? num_cycles  : n_q;

  always_comb begin
    state_nxt = state;
    case (state)
      T_IDLE: if (start_c) state_nxt = T_RUN;
      T_RUN: begin
        if (kill_c)          state_nxt = T_IDLE;
        else if (all_idle_c) state_nxt = T_DONE;
      end
      T_DONE:  state_nxt = T_IDLE;
      default: state_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= T_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != T_IDLE);
      done  <= (state_nxt == T_DONE);
    end
  end

  // Event configuration is frozen on the accepting edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dly_q <= '0;
      h_q   <= '0;
      d_q   <= '0;
      n_q   <= '0;
    end else if (start_c) begin
      dly_q <= delays;
      h_q   <= half_period;
      d_q   <= dead_time;
      n_q   <= num_cycles;
    end
  end

  for (genvar i = 0; i < NUM_ELEM; i++) begin : g_ch
    tx_pulse_channel #(
      .DELAY_W (DELAY_W),
      .HALF_W  (HALF_W),
      .CYC_W   (CYC_W)
    ) u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start_c),
      .kill        (kill_c),
      .delay       (dly_eff[i*DELAY_W +: DELAY_W]),
      .half_period (h_eff),
      .dead_time   (d_eff),
      .num_cycles  (n_eff),
      .pos         (ch_pos[i]),
      .neg         (ch_neg[i]),
      .idle_c      (ch_idle_c[i])
    );
  end

  assign posOutput = ch_pos;
  assign negOutput = ch_neg;

endmodule
